// File: rtl/fetch_prefetcher_if.sv
// Icache read port and FIFO write port seen by the fetch prefetcher.
// master = prefetcher side, slave = icache/FIFO side.
interface fetch_prefetcher_if;
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             ihit;
  logic [31:0]      imemload;
  logic [1:0][31:0] FIFO_in;
  logic             FIFO_WEN;
  logic             FIFO_full;

  modport master (
    output imemREN, imemaddr, FIFO_in, FIFO_WEN,
    input  ihit, imemload, FIFO_full
  );

  modport slave (
    input  imemREN, imemaddr, FIFO_in, FIFO_WEN,
    output ihit, imemload, FIFO_full
  );
endinterface

// File: rtl/fetch_prefetcher.sv
// Sequential instruction fetcher feeding the 4-entry instruction FIFO with {next_pc, instr}.
// Optional PREFETCH_HALT_EN: stop fetching after pushing the 32'hFFFFFFFF halt word.
module fetch_prefetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_prefetcher_if.master  bus,
  output logic [31:0]         fetch_pc,
  output logic                halted
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] PUSH   = 2'd1;
`ifdef PREFETCH_HALT_EN
  localparam logic [1:0] HALTED = 2'd2;
`endif

  logic [1:0]       state;
  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic [1:0][31:0] hold;
  logic [1:0][31:0] live;
  logic             live_halt;
  logic             hold_halt;

  always_comb begin
    pc_next = pc + PC_STEP;
    live    = {pc_next, bus.imemload};
`ifdef PREFETCH_HALT_EN
    live_halt = (bus.imemload == '1);
    hold_halt = (hold[0] == '1);
`else
    live_halt = 1'b0;
    hold_halt = 1'b0;
`endif
  end

  always_comb begin
    bus.imemREN  = (state == FETCH);
    bus.imemaddr = pc;
    bus.FIFO_WEN = 1'b0;
    bus.FIFO_in  = (state == PUSH) ? hold : live;
    if (RST) begin
      bus.FIFO_in = '0;
    end else if (!redirect && !bus.FIFO_full) begin
      if (state == FETCH) bus.FIFO_WEN = bus.ihit;
      else if (state == PUSH) bus.FIFO_WEN = 1'b1;
    end
  end

  assign fetch_pc = pc;
`ifdef PREFETCH_HALT_EN
  assign halted = (state == HALTED);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      pc    <= RESET_PC;
      hold  <= '0;
    end else if (redirect) begin
      state <= FETCH;
      pc    <= redirect_pc;
      hold  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.ihit) begin
            pc <= pc_next;
            if (bus.FIFO_full) begin
              hold  <= live;
              state <= PUSH;
            end else if (live_halt) begin
`ifdef PREFETCH_HALT_EN
              state <= HALTED;
`endif
            end
          end
        end
        PUSH: begin
          if (!bus.FIFO_full) begin
`ifdef PREFETCH_HALT_EN
            state <= hold_halt ? HALTED : FETCH;
`else
            state <= FETCH;
`endif
          end
        end
`ifdef PREFETCH_HALT_EN
        HALTED: state <= HALTED;
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetcher.sv
// Scoreboard bench for fetch_prefetcher: driver + reference model push expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_fetch_prefetcher;

`ifdef PREFETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_pc;
  logic        halted;

  fetch_prefetcher_if bus ();

  fetch_prefetcher #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .CLK(CLK), .RST(RST), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus(bus), .fetch_pc(fetch_pc), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] nxt; logic [31:0] ins; } ent_t;
  typedef struct { bit ren; bit wen; logic [31:0] addr; bit hlt; } cyc_t;

  ent_t exp_q[$];
  cyc_t cyc_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: current fetch address, optional entry waiting on FIFO space, halt flag.
  logic [31:0] m_pc = RST_PC;
  bit          m_held = 1'b0;
  ent_t        m_entry;
  bit          m_halted = 1'b0;
  bit          halt_word_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {1'b0, a[30:0] ^ 31'h2A5A_1111};
  endfunction

  function automatic logic [31:0] ld();
    return (halt_word_on && m_pc == 32'h10) ? 32'hFFFF_FFFF : dat(m_pc);
  endfunction

  task automatic step(input bit r, input bit red, input logic [31:0] rpc,
                      input bit hit, input bit full, input logic [31:0] load);
    cyc_t c;
    ent_t e;
    bit   push;
    @(posedge CLK); #1;
    RST = r; redirect = red; redirect_pc = rpc;
    bus.ihit = hit; bus.FIFO_full = full; bus.imemload = load;
    if (r) begin
      m_pc = RST_PC; m_held = 1'b0; m_halted = 1'b0;
    end else begin
      push = 1'b0;
      e = '{nxt: m_pc + 32'd4, ins: load};
      if (!red) begin
        if (m_held) begin
          push = !full;
          e = m_entry;
        end else if (!m_halted && hit) begin
          push = !full;
        end
      end
      c = '{ren: !m_held && !m_halted, wen: push, addr: m_pc, hlt: m_halted};
      cyc_q.push_back(c);
      if (push) exp_q.push_back(e);
      if (red) begin
        m_pc = rpc; m_held = 1'b0; m_halted = 1'b0;
      end else if (m_held) begin
        if (!full) begin
          m_held = 1'b0;
          m_halted = HALT_EN && (m_entry.ins == 32'hFFFF_FFFF);
        end
      end else if (!m_halted && hit) begin
        m_pc = m_pc + 32'd4;
        if (full) begin
          m_held = 1'b1; m_entry = e;
        end else begin
          m_halted = HALT_EN && (load == 32'hFFFF_FFFF);
        end
      end
    end
  endtask

  task automatic tk(input bit hit, input bit full);
    step(1'b0, 1'b0, '0, hit, full, ld());
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  always @(negedge CLK) begin
    cyc_t c;
    ent_t e;
    if (RST) begin
      chk("wen_in_reset", {31'b0, bus.FIFO_WEN}, 32'd0);
    end else if (cyc_q.size() == 0) begin
      chk("cycle_expectation_missing", 32'd0, 32'd1);
    end else begin
      c = cyc_q.pop_front();
      chk("imemREN", {31'b0, bus.imemREN}, {31'b0, c.ren});
      chk("FIFO_WEN", {31'b0, bus.FIFO_WEN}, {31'b0, c.wen});
      chk("imemaddr", bus.imemaddr, c.addr);
      chk("fetch_pc", fetch_pc, c.addr);
      chk("halted", {31'b0, halted}, {31'b0, c.hlt});
      chk("wen_while_full", {31'b0, bus.FIFO_WEN & bus.FIFO_full}, 32'd0);
      if (bus.FIFO_WEN) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_push", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("FIFO_in_next_pc", bus.FIFO_in[1], e.nxt);
          chk("FIFO_in_instr", bus.FIFO_in[0], e.ins);
        end
      end
    end
  end

  initial begin
    bus.ihit = 1'b0; bus.FIFO_full = 1'b0; bus.imemload = '0;
    do_reset();

    // free-running fetch from reset
    for (int unsigned i = 0; i < 4; i++) tk(1'b1, 1'b0);

    // full at pc=8, released after 3 cycles
    do_reset();
    tk(1'b1, 1'b0); tk(1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h8C01_0000);
    for (int unsigned i = 0; i < 3; i++) tk(1'($urandom_range(0, 1)), 1'b1);
    tk(1'b1, 1'b0); tk(1'b1, 1'b0);

    // redirect coinciding with ihit at 0x40
    do_reset();
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, ld());
    tk(1'b1, 1'b0); tk(1'b1, 1'b0);

    // redirect while holding an entry
    tk(1'b1, 1'b1); tk(1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h300, 1'b0, 1'b1, '0);
    tk(1'b0, 1'b0); tk(1'b1, 1'b0); tk(1'b1, 1'b0);

    // reset while holding an entry
    tk(1'b1, 1'b1); tk(1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, '0);
    tk(1'b1, 1'b0); tk(1'b1, 1'b0);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0);
    tk(1'b1, 1'b0); tk(1'b1, 1'b0);

    // halt word at 0x10, idle, then redirect back to 0
    do_reset();
    halt_word_on = 1'b1;
    for (int unsigned i = 0; i < 15; i++) tk(1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, ld());
    for (int unsigned i = 0; i < 3; i++) tk(1'b1, 1'b0);
    // halt word captured while full
    do_reset();
    for (int unsigned i = 0; i < 4; i++) tk(1'b1, 1'b0);
    tk(1'b1, 1'b1); tk(1'b1, 1'b1);
    for (int unsigned i = 0; i < 6; i++) tk(1'b1, 1'b0);
    halt_word_on = 1'b0;

    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      logic [31:0] load;
      rpc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      load = ($urandom_range(0, 29) == 0) ? 32'hFFFF_FFFF : $urandom();
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 19) == 0), rpc,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), load);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    @(negedge CLK); #1;
    chk("pending_pushes", exp_q.size(), 32'd0);
    chk("pending_cycles", cyc_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
